uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_sync.sv | 33 +++
 rtl/uart_rx.sv | 192 +++++++++++++++++++
 tb/tb_uart_rx.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg -- shared definitions for the UART receive path.
//   UART_WIDTH  : default number of data bits per frame
//   SYNC_STAGES : depth of the rx input synchronizer
//   rx_state_t  : receiver state encoding. RX_PARITY exists only when the
//                 UART_RX_PARITY_EN macro is defined.
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int UART_WIDTH  = 8;
  localparam int SYNC_STAGES = 2;

  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_START     = 3'd1,
    RX_DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
    RX_PARITY    = 3'd3,
`endif
    RX_STOP      = 3'd4,
    RX_WAIT_IDLE = 3'd5
  } rx_state_t;

endpackage

// File: rtl/uart_sync.sv
// -----------------------------------------------------------------------------
// uart_sync -- STAGES-deep flop chain that brings an asynchronous level into
// the clock domain. All flops reset to 1, which is the idle level of a UART
// line, so no false start bit is seen when reset releases.
//   clock   : destination clock
//   reset_n : asynchronous active-low reset
//   d       : asynchronous input
//   q       : synchronized output (STAGES cycles of latency)
// STAGES must be at least 2.
// -----------------------------------------------------------------------------
module uart_sync
  import uart_pkg::*;
#(
  parameter int STAGES = SYNC_STAGES
) (
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) sync_q <= '1;
    else          sync_q <= {sync_q[STAGES-2:0], d};
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx -- UART receiver: start bit, WIDTH data bits LSB first, optional
// even-parity bit, one stop bit. Bit period P = clock_divider + 1 clocks
// (a divider of 0 behaves as 1). Each bit is sampled mid-period: the start
// bit is confirmed P/2 cycles after the falling edge, later bits every P.
//
// Ports
//   clock, reset_n : clock and asynchronous active-low reset
//   clock_divider  : bit period minus one, latched when a start edge is seen
//   rx             : serial line, idle high, asynchronous
//   read_en        : consume the held byte
//   data_out       : last accepted byte, stable while data_valid is high
//   data_valid     : data_out holds an unread byte
//   overrun        : sticky, a good frame arrived while a byte was unread
//   frame_error    : one-cycle pulse when the stop bit samples low
//   parity_error   : one-cycle pulse on a parity mismatch (0 without parity)
//
// Build option: define UART_RX_PARITY_EN to expect one even-parity bit
// between the data bits and the stop bit.
// WIDTH must be at least 2.
// -----------------------------------------------------------------------------
module uart_rx
  import uart_pkg::*;
#(
  parameter int WIDTH = UART_WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [15:0]      clock_divider,
  input  logic             rx,
  input  logic             read_en,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             overrun,
  output logic             frame_error,
  output logic             parity_error
);

  localparam int               BIT_W    = $clog2(WIDTH + 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);

  rx_state_t        state, next_state;
  logic             rx_s;
  logic [16:0]      period_now;  // P for the current divider value
  logic [16:0]      period;      // P latched for the frame in progress
  logic [16:0]      cnt;         // cycles left until the next sample
  logic [BIT_W-1:0] bit_cnt;
  logic [WIDTH-1:0] shift;
  logic             expire;
  logic             start_det, reload, data_sample, stop_sample;
  logic             accept, frame_bad;

  uart_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (rx),
    .q       (rx_s)
  );

  assign period_now = (clock_divider == 16'd0) ? 17'd2
                                               : {1'b0, clock_divider} + 17'd1;
  // The counter is loaded with N and the sample is taken N edges later.
  assign expire = (cnt == 17'd1);

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= RX_IDLE;
    else          state <= next_state;
  end

  // --------------------------------------------------------------- next state
  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      RX_IDLE:      if (!rx_s) next_state = RX_START;
      // A start bit that is high again at mid-bit was only a glitch.
      RX_START:     if (expire) next_state = rx_s ? RX_IDLE : RX_DATA;
      RX_DATA: begin
        if (expire && bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
          next_state = RX_PARITY;
`else
          next_state = RX_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      RX_PARITY:    if (expire) next_state = RX_STOP;
`endif
      RX_STOP:      if (expire) next_state = rx_s ? RX_IDLE : RX_WAIT_IDLE;
      // A held-low line (break) must not be decoded as a stream of frames.
      RX_WAIT_IDLE: if (rx_s) next_state = RX_IDLE;
      default:      next_state = RX_IDLE;
    endcase
  end

  // ------------------------------------------------------------ output decode
  always_comb begin
    start_det   = 1'b0;
    reload      = 1'b0;
    data_sample = 1'b0;
    stop_sample = 1'b0;
    case (state)
      RX_IDLE:   start_det = !rx_s;
      RX_START:  reload    = expire && !rx_s;
      RX_DATA: begin
        data_sample = expire;
        reload      = expire;
      end
`ifdef UART_RX_PARITY_EN
      RX_PARITY: reload    = expire;
`endif
      RX_STOP:   stop_sample = expire;
      default: ;
    endcase
  end

  assign frame_bad = stop_sample && !rx_s;

`ifdef UART_RX_PARITY_EN
  logic par_sample, par_mismatch, par_bad;

  assign par_sample   = (state == RX_PARITY) && expire;
  assign par_mismatch = rx_s != (^shift);
  // A parity failure discards the byte but the stop bit is still checked.
  assign accept       = stop_sample && rx_s && !par_bad;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      par_bad      <= 1'b0;
      parity_error <= 1'b0;
    end else begin
      parity_error <= par_sample && par_mismatch;
      if (start_det)       par_bad <= 1'b0;
      else if (par_sample) par_bad <= par_mismatch;
    end
  end
`else
  assign accept       = stop_sample && rx_s;
  assign parity_error = 1'b0;
`endif

  // ---------------------------------------------------- bit timing and shifter
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt     <= '0;
      period  <= '0;
      bit_cnt <= '0;
      shift   <= '0;
    end else begin
      if (start_det) begin
        cnt     <= period_now >> 1;
        period  <= period_now;
        bit_cnt <= '0;
      end else if (reload) begin
        cnt <= period;
      end else if (cnt != 17'd0) begin
        cnt <= cnt - 17'd1;
      end
      if (data_sample) begin
        shift   <= {rx_s, shift[WIDTH-1:1]};
        bit_cnt <= bit_cnt + BIT_W'(1);
      end
    end
  end

  // ------------------------------------------------------------ host interface
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      data_out    <= '0;
      data_valid  <= 1'b0;
      overrun     <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      frame_error <= frame_bad;
      if (accept) begin
        // A read on the same edge frees the holding register for the new byte.
        if (!data_valid || read_en) begin
          data_out   <= shift;
          data_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (read_en) begin
        data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx -- self-checking bench for uart_rx (WIDTH = 8).
// Frames are built as bit-slot vectors and driven one slot per bit period.
// Expected results come from a frame-level model: a holding register with a
// valid flag and a sticky overrun flag, plus pulse counters for the errors.
// Define UART_RX_PARITY_EN for both files to exercise the parity build.
// -----------------------------------------------------------------------------
module tb_uart_rx;

  localparam int W = 8;
`ifdef UART_RX_PARITY_EN
  localparam int NSLOT = 11;  // start, 8 data, parity, stop
`else
  localparam int NSLOT = 10;  // start, 8 data, stop
`endif

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic [15:0]  clock_divider = 16'd1;
  logic         rx = 1'b1;
  logic         read_en = 1'b0;
  logic [W-1:0] data_out;
  logic         data_valid, overrun, frame_error, parity_error;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   fe_cnt  = 0;
  int   pe_cnt  = 0;
  int   rise_cyc = -1;
  logic dv_prev = 1'b0;

  uart_rx #(.WIDTH(W)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .clock_divider (clock_divider),
    .rx            (rx),
    .read_en       (read_en),
    .data_out      (data_out),
    .data_valid    (data_valid),
    .overrun       (overrun),
    .frame_error   (frame_error),
    .parity_error  (parity_error)
  );

  always #5 clock = ~clock;

  // Rising edges counted so negedge-time reads see a stable value.
  always @(posedge clock) cyc <= cyc + 1;

  // Error pulses are one cycle wide, so high cycles equal pulse count.
  always @(negedge clock) begin
    if (frame_error === 1'b1) fe_cnt++;
    if (parity_error === 1'b1) pe_cnt++;
    if (data_valid === 1'b1 && dv_prev !== 1'b1) rise_cyc = cyc;
    dv_prev = data_valid;
  end

  // ------------------------------------------------------------- model helpers
  function automatic int period_of(input logic [15:0] d);
    return (d == 16'd0) ? 2 : int'(d) + 1;
  endfunction

  function automatic bit even_par(input logic [7:0] b);
    return bit'($countones(b) % 2);
  endfunction

  // Cycles from driving the start bit to data_valid being visible:
  // two synchronizer flops, one detection edge, half a bit to mid-start,
  // then one full period per remaining slot up to the stop sample.
  function automatic int latency(input int p);
    return 3 + p / 2 + (NSLOT - 1) * p;
  endfunction

  function automatic logic [11:0] build_frame(input logic [7:0] b,
                                              input bit stop_bit,
                                              input bit par_bit);
    logic [11:0] f;
    f = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[1 + i] = b[i];
    if (NSLOT == 11) f[9] = par_bit;
    f[NSLOT - 1] = stop_bit;
    return f;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Leaves rx at the last slot value so a low stop can be extended.
  task automatic drive_slots(input logic [11:0] f, input int n, input int p);
    for (int i = 0; i < n; i++) begin
      rx = f[i];
      repeat (p) @(negedge clock);
    end
  endtask

  task automatic send(input logic [7:0] b, input int p);
    drive_slots(build_frame(b, 1'b1, even_par(b)), NSLOT, p);
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    rx = 1'b1;
    tick(2);
    reset_n = 1'b1;
    tick(2);
  endtask

  // ---------------------------------------------------------------- scenarios
  task automatic test_reset();
    reset_n = 1'b0;
    rx = 1'b1;
    tick(3);
    n_tests++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", data_out); end
    n_tests++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", data_valid); end
    n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    n_tests++; if (frame_error !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b want 0", frame_error); end
    n_tests++; if (parity_error !== 1'b0) begin n_fail++; $display("FAIL reset_parity_err: got %b want 0", parity_error); end
    reset_n = 1'b1;
    tick(3);
  endtask

  task automatic test_basic();
    int p, c0, fe0, pe0;
    clock_divider = 16'd1;
    p = period_of(clock_divider);
    fe0 = fe_cnt; pe0 = pe_cnt;
    c0 = cyc;
    send(8'hAA, p);
    tick(4);
    n_tests++; if (rise_cyc - c0 !== latency(p)) begin n_fail++; $display("FAIL basic_latency: got %0d want %0d", rise_cyc - c0, latency(p)); end
    n_tests++; if (data_out !== 8'hAA) begin n_fail++; $display("FAIL basic_data: got %h want aa", data_out); end
    n_tests++; if (data_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b want 1", data_valid); end
    n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL basic_overrun: got %b want 0", overrun); end
    n_tests++; if (fe_cnt !== fe0) begin n_fail++; $display("FAIL basic_frame_err: got %0d pulses want 0", fe_cnt - fe0); end
    n_tests++; if (pe_cnt !== pe0) begin n_fail++; $display("FAIL basic_parity_err: got %0d pulses want 0", pe_cnt - pe0); end
    read_en = 1'b1; tick(1); read_en = 1'b0;
    n_tests++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL basic_read: valid got %b want 0", data_valid); end
    // A read with nothing held must change nothing.
    read_en = 1'b1; tick(1); read_en = 1'b0; tick(1);
    n_tests++; if (data_valid !== 1'b0 || overrun !== 1'b0) begin n_fail++; $display("FAIL basic_idle_read: valid %b overrun %b want 0 0", data_valid, overrun); end
  endtask

  task automatic test_glitch();
    int fe0;
    clock_divider = 16'd3;
    fe0 = fe_cnt;
    rx = 1'b0; tick(1); rx = 1'b1;
    tick(30);
    n_tests++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL glitch_valid: got %b want 0", data_valid); end
    n_tests++; if (fe_cnt !== fe0 || overrun !== 1'b0) begin n_fail++; $display("FAIL glitch_flags: fe %0d overrun %b want 0 0", fe_cnt - fe0, overrun); end
    // Receiver must be back in idle and decode a frame at this divider.
    send(8'h96, period_of(clock_divider));
    tick(4);
    n_tests++; if (data_valid !== 1'b1 || data_out !== 8'h96) begin n_fail++; $display("FAIL glitch_recover: valid %b data %h want 1 96", data_valid, data_out); end
    read_en = 1'b1; tick(1); read_en = 1'b0;
  endtask

  task automatic test_overrun();
    int p;
    clock_divider = 16'd1;
    p = period_of(clock_divider);
    send(8'h55, p);
    send(8'h0F, p);
    tick(4);
    n_tests++; if (data_out !== 8'h55) begin n_fail++; $display("FAIL overrun_data: got %h want 55", data_out); end
    n_tests++; if (data_valid !== 1'b1) begin n_fail++; $display("FAIL overrun_valid: got %b want 1", data_valid); end
    n_tests++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_set: got %b want 1", overrun); end
    read_en = 1'b1; tick(1); read_en = 1'b0;
    tick(5);
    n_tests++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL overrun_read: valid got %b want 0", data_valid); end
    n_tests++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_sticky: got %b want 1", overrun); end
  endtask

  task automatic test_break();
    int p, fe0;
    clock_divider = 16'd1;
    p = period_of(clock_divider);
    fe0 = fe_cnt;
    drive_slots(build_frame(8'h3C, 1'b0, even_par(8'h3C)), NSLOT, p);
    tick(40);
    rx = 1'b1;
    tick(6);
    n_tests++; if (fe_cnt - fe0 !== 1) begin n_fail++; $display("FAIL break_pulses: got %0d want 1", fe_cnt - fe0); end
    n_tests++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL break_valid: got %b want 0", data_valid); end
    send(8'h81, p);
    tick(4);
    n_tests++; if (data_valid !== 1'b1 || data_out !== 8'h81) begin n_fail++; $display("FAIL break_next: valid %b data %h want 1 81", data_valid, data_out); end
    read_en = 1'b1; tick(1); read_en = 1'b0;
  endtask

  task automatic test_coincide();
    int p, lat;
    pulse_reset();
    clock_divider = 16'd2;
    p = period_of(clock_divider);
    lat = latency(p);
    send(8'h12, p);
    tick(4);
    // Second frame arrives with a read landing on its stop-sample edge.
    fork
      send(8'h34, p);
      begin
        tick(lat - 1);
        read_en = 1'b1;
        tick(1);
        read_en = 1'b0;
      end
    join
    tick(4);
    n_tests++; if (data_out !== 8'h34) begin n_fail++; $display("FAIL coincide_data: got %h want 34", data_out); end
    n_tests++; if (data_valid !== 1'b1) begin n_fail++; $display("FAIL coincide_valid: got %b want 1", data_valid); end
    n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL coincide_overrun: got %b want 0", overrun); end
    read_en = 1'b1; tick(1); read_en = 1'b0;
  endtask

  task automatic test_random();
    logic [7:0] exp_data;
    bit         exp_valid, exp_ov, bad;
    int         p, fe0;
    logic [7:0] b;
    pulse_reset();
    exp_data = '0; exp_valid = 1'b0; exp_ov = 1'b0;
    for (int n = 0; n < 24; n++) begin
      clock_divider = 16'($urandom_range(0, 5));
      p   = period_of(clock_divider);
      b   = 8'($urandom);
      bad = ($urandom_range(0, 5) == 0);
      fe0 = fe_cnt;
      drive_slots(build_frame(b, !bad, even_par(b)), NSLOT, p);
      rx = 1'b1;
      tick(4 + $urandom_range(0, 3));
      if (!bad) begin
        if (!exp_valid) begin exp_data = b; exp_valid = 1'b1; end
        else exp_ov = 1'b1;
      end
      n_tests++; if (fe_cnt - fe0 !== int'(bad)) begin n_fail++; $display("FAIL rand%0d_frame_err: got %0d want %0d", n, fe_cnt - fe0, int'(bad)); end
      n_tests++; if (data_valid !== exp_valid) begin n_fail++; $display("FAIL rand%0d_valid: got %b want %b", n, data_valid, exp_valid); end
      if (exp_valid) begin
        n_tests++; if (data_out !== exp_data) begin n_fail++; $display("FAIL rand%0d_data: got %h want %h", n, data_out, exp_data); end
      end
      n_tests++; if (overrun !== exp_ov) begin n_fail++; $display("FAIL rand%0d_overrun: got %b want %b", n, overrun, exp_ov); end
      if ($urandom_range(0, 1) == 1) begin
        read_en = 1'b1; tick(1); read_en = 1'b0;
        exp_valid = 1'b0;
        n_tests++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL rand%0d_read: valid got %b want 0", n, data_valid); end
      end
    end
    if (exp_valid) begin read_en = 1'b1; tick(1); read_en = 1'b0; end
  endtask

  task automatic test_mid_reset();
    int          p, fe0;
    logic [11:0] f;
    clock_divider = 16'd1;
    send(8'h11, 2);
    send(8'h22, 2);
    tick(4);
    // Slow frame, interrupted while its data bit 4 is on the line.
    clock_divider = 16'd7;
    p = period_of(clock_divider);
    f = build_frame(8'h5A, 1'b1, even_par(8'h5A));
    drive_slots(f, 5, p);
    rx = f[5];
    tick(4);
    reset_n = 1'b0;
    rx = 1'b1;
    tick(1);
    n_tests++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL midrst_data: got %h want 00", data_out); end
    n_tests++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b want 0", data_valid); end
    n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL midrst_overrun: got %b want 0", overrun); end
    n_tests++; if (frame_error !== 1'b0 || parity_error !== 1'b0) begin n_fail++; $display("FAIL midrst_pulses: fe %b pe %b want 0 0", frame_error, parity_error); end
    tick(2);
    reset_n = 1'b1;
    fe0 = fe_cnt;
    tick(12 * p);
    n_tests++; if (data_valid !== 1'b0 || fe_cnt !== fe0) begin n_fail++; $display("FAIL midrst_abandon: valid %b fe %0d want 0 0", data_valid, fe_cnt - fe0); end
    send(8'hC3, p);
    tick(4);
    n_tests++; if (data_valid !== 1'b1 || data_out !== 8'hC3) begin n_fail++; $display("FAIL midrst_next: valid %b data %h want 1 c3", data_valid, data_out); end
    read_en = 1'b1; tick(1); read_en = 1'b0;
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    int pe0, fe0;
    clock_divider = 16'd1;
    pe0 = pe_cnt; fe0 = fe_cnt;
    drive_slots(build_frame(8'h01, 1'b1, 1'b0), NSLOT, 2);
    tick(4);
    n_tests++; if (pe_cnt - pe0 !== 1) begin n_fail++; $display("FAIL parity_bad_pulse: got %0d want 1", pe_cnt - pe0); end
    n_tests++; if (data_valid !== 1'b0 || fe_cnt !== fe0) begin n_fail++; $display("FAIL parity_bad_drop: valid %b fe %0d want 0 0", data_valid, fe_cnt - fe0); end
    drive_slots(build_frame(8'h01, 1'b1, 1'b1), NSLOT, 2);
    tick(4);
    n_tests++; if (data_valid !== 1'b1 || data_out !== 8'h01) begin n_fail++; $display("FAIL parity_good: valid %b data %h want 1 01", data_valid, data_out); end
    n_tests++; if (pe_cnt - pe0 !== 1) begin n_fail++; $display("FAIL parity_good_pulse: got %0d extra want 0", pe_cnt - pe0 - 1); end
    read_en = 1'b1; tick(1); read_en = 1'b0;
  endtask
`else
  task automatic test_parity();
    n_tests++; if (pe_cnt !== 0) begin n_fail++; $display("FAIL parity_off: got %0d pulses want 0", pe_cnt); end
  endtask
`endif

  initial begin
    tick(1);
    test_reset();
    test_basic();
    test_glitch();
    test_overrun();
    test_break();
    test_coincide();
    test_random();
    test_mid_reset();
    test_parity();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
